// File: rtl/elementwise_mult_scheduler.sv
// elementwise_mult_scheduler
// Shares one N x N unsigned multiplier between two vector requesters.
// A granted job's operand vectors are captured, multiplied one element per
// cycle, and the full product vector is held until the consumer takes it.

module elementwise_mult_scheduler #(
  parameter int N   = 8,
  parameter int LEN = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [LEN*N-1:0]     req0_a,
  input  logic [LEN*N-1:0]     req0_b,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [LEN*N-1:0]     req1_a,
  input  logic [LEN*N-1:0]     req1_b,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic                 res_id,
  output logic [LEN*2*N-1:0]   res_data,
  output logic                 busy
);

  localparam int IW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [IW-1:0]      idx;
  logic               last_grant;
  logic               grant;
  logic               accept;
  logic [LEN*N-1:0]   sel_a;
  logic [LEN*N-1:0]   sel_b;
  logic [N-1:0]       a_reg   [LEN];
  logic [N-1:0]       b_reg   [LEN];
  logic [2*N-1:0]     res_mem [LEN];
  logic [N-1:0]       a_el;
  logic [N-1:0]       b_el;
  logic [2*N-1:0]     prod;

  // Round-robin pick: a lone requester always wins, contention goes to the
  // requester that did not win last time.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  // A job is only accepted in IDLE and never while reset is asserted, so
  // both readys read 0 during reset even with valids high.
  assign accept     = rst_n && (state == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = accept && !grant;
  assign req1_ready = accept && grant;

  // Operand source for the capture at handshake.
  always_comb begin
    sel_a = req0_a;
    sel_b = req0_b;
    if (grant) begin
      sel_a = req1_a;
      sel_b = req1_b;
    end
  end

  // Single shared multiplier working on the current captured element pair,
  // widened first so the full 2N-bit product is kept.
  always_comb begin
    a_el = a_reg[idx];
    b_el = b_reg[idx];
    prod = {{N{1'b0}}, a_el} * {{N{1'b0}}, b_el};
  end

  // Present the per-element result registers as the packed output vector.
  for (genvar g = 0; g < LEN; g++) begin : g_pack
    assign res_data[g*2*N +: 2*N] = res_mem[g];
  end

  // Scheduler FSM: arbitration and capture in IDLE, element loop in MUL,
  // result hold in DONE until the consumer handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      res_valid  <= 1'b0;
      res_id     <= 1'b0;
      busy       <= 1'b0;
      last_grant <= 1'b1;
      for (int i = 0; i < LEN; i++) begin
        a_reg[i]   <= '0;
        b_reg[i]   <= '0;
        res_mem[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            for (int i = 0; i < LEN; i++) begin
              a_reg[i] <= sel_a[i*N +: N];
              b_reg[i] <= sel_b[i*N +: N];
            end
            res_id     <= grant;
            last_grant <= grant;
            idx        <= '0;
            busy       <= 1'b1;
            state      <= MUL;
          end
        end
        MUL: begin
          res_mem[idx] <= prod;
          if (idx == LAST_IDX) begin
            idx       <= '0;
            res_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          res_valid <= 1'b0;
          busy      <= 1'b0;
          idx       <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_elementwise_mult_scheduler.sv
// tb_elementwise_mult_scheduler
// Directed and randomized jobs against a vector-level reference model of
// the scheduler: round-robin winner, elementwise products and fixed timing.

module tb_elementwise_mult_scheduler;

  localparam int N   = 8;
  localparam int LEN = 8;
  localparam int VW  = LEN * N;
  localparam int RW  = LEN * 2 * N;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0_valid = 1'b0;
  logic          req0_ready;
  logic [VW-1:0] req0_a = '0;
  logic [VW-1:0] req0_b = '0;
  logic          req1_valid = 1'b0;
  logic          req1_ready;
  logic [VW-1:0] req1_a = '0;
  logic [VW-1:0] req1_b = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic          res_id;
  logic [RW-1:0] res_data;
  logic          busy;

  int   tests = 0;
  int   fails = 0;
  logic model_last = 1'b1;

  elementwise_mult_scheduler #(.N(N), .LEN(LEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_id     (res_id),
    .res_data   (res_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Reference: each result element is the plain integer product of the
  // matching operand elements.
  function automatic logic [RW-1:0] expProducts(input logic [VW-1:0] a, input logic [VW-1:0] b);
    logic [RW-1:0] r;
    int unsigned   ai, bi, p;
    r = '0;
    for (int i = 0; i < LEN; i++) begin
      ai = 32'(a[i*N +: N]);
      bi = 32'(b[i*N +: N]);
      p  = ai * bi;
      r[i*2*N +: 2*N] = p[2*N-1:0];
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("[TB] check %s differs", tag);
    end
  endtask

  // Assert reset, check every output is cleared, release on a falling edge.
  task automatic doReset();
    rst_n = 1'b0;
    #1;
    checkOutput("rst_res_valid", RW'(res_valid), RW'(0));
    checkOutput("rst_busy", RW'(busy), RW'(0));
    checkOutput("rst_res_id", RW'(res_id), RW'(0));
    checkOutput("rst_res_data", res_data, RW'(0));
    checkOutput("rst_readys", RW'({req0_ready, req1_ready}), RW'(0));
    @(negedge clk);
    rst_n      = 1'b1;
    model_last = 1'b1;
  endtask

  // One complete job starting at a falling edge in IDLE: handshake, LEN
  // multiply cycles, result, optional backpressure, return to IDLE.
  task automatic applyStimulus(input logic v0, input logic v1,
                               input logic [VW-1:0] a0, input logic [VW-1:0] b0,
                               input logic [VW-1:0] a1, input logic [VW-1:0] b1,
                               input int hold, input bit scramble);
    logic          win;
    logic [RW-1:0] exp_data;
    win      = (v0 && v1) ? ~model_last : v1;
    exp_data = win ? expProducts(a1, b1) : expProducts(a0, b0);
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
    res_ready  = 1'b1;
    #1;
    checkOutput("hs_ready0", RW'(req0_ready), RW'(!win));
    checkOutput("hs_ready1", RW'(req1_ready), RW'(win));
    checkOutput("hs_busy", RW'(busy), RW'(0));
    model_last = win;
    for (int c = 1; c <= LEN; c++) begin
      @(negedge clk);
      if (c == 1 && scramble) begin
        req0_a = {(VW/8){8'hAA}};
        req0_b = {(VW/8){8'h55}};
        req1_a = {(VW/8){8'hAA}};
        req1_b = {(VW/8){8'h55}};
      end
      #1;
      checkOutput("mul_busy", RW'(busy), RW'(1));
      checkOutput("mul_res_valid", RW'(res_valid), RW'(0));
      checkOutput("mul_readys", RW'({req0_ready, req1_ready}), RW'(0));
    end
    @(negedge clk);
    res_ready = (hold == 0);
    #1;
    checkOutput("done_res_valid", RW'(res_valid), RW'(1));
    checkOutput("done_busy", RW'(busy), RW'(1));
    checkOutput("done_res_id", RW'(res_id), RW'(win));
    checkOutput("done_res_data", res_data, exp_data);
    checkOutput("done_readys", RW'({req0_ready, req1_ready}), RW'(0));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (h == hold - 1) res_ready = 1'b1;
      #1;
      checkOutput("bp_res_valid", RW'(res_valid), RW'(1));
      checkOutput("bp_res_id", RW'(res_id), RW'(win));
      checkOutput("bp_res_data", res_data, exp_data);
      checkOutput("bp_readys", RW'({req0_ready, req1_ready}), RW'(0));
    end
    @(negedge clk);
    #1;
    checkOutput("post_res_valid", RW'(res_valid), RW'(0));
    checkOutput("post_busy", RW'(busy), RW'(0));
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    logic [VW-1:0] va, vb, vc, vd, ones, zero;
    logic [1:0]    sel;

    // Power-on reset.
    #2;
    doReset();

    // Single job from requester 0: a[i]=i+1, b[i]=2.
    for (int i = 0; i < LEN; i++) begin
      va[i*N +: N] = N'(i + 1);
      vb[i*N +: N] = N'(2);
    end
    applyStimulus(1'b1, 1'b0, va, vb, '0, '0, 0, 1'b0);

    // Full-width products and zero operands, from requester 1 alone.
    ones = {(VW/8){8'hFF}};
    zero = '0;
    applyStimulus(1'b0, 1'b1, '0, '0, ones, ones, 0, 1'b0);
    applyStimulus(1'b0, 1'b1, '0, '0, zero, {$urandom, $urandom}, 0, 1'b0);

    // Round robin after reset: both valid for four jobs.
    doReset();
    for (int i = 0; i < LEN; i++) begin
      va[i*N +: N] = N'(i);
      vb[i*N +: N] = N'(3);
      vd[i*N +: N] = N'(5);
    end
    for (int j = 0; j < 4; j++) begin
      applyStimulus(1'b1, 1'b1, va, vb, va, vd, 0, 1'b0);
    end

    // Backpressure: result held for five cycles.
    applyStimulus(1'b1, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, '0, '0, 5, 1'b0);

    // Operand isolation: inputs overwritten right after the handshake.
    applyStimulus(1'b1, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, '0, '0, 0, 1'b1);
    applyStimulus(1'b1, 1'b1, {$urandom, $urandom}, {$urandom, $urandom},
                  {$urandom, $urandom}, {$urandom, $urandom}, 1, 1'b1);

    // Randomized jobs: random requester mix, operands and backpressure.
    for (int j = 0; j < 10; j++) begin
      sel = 2'($urandom_range(1, 3));
      va = {$urandom, $urandom};
      vb = {$urandom, $urandom};
      vc = {$urandom, $urandom};
      vd = {$urandom, $urandom};
      applyStimulus(sel[0], sel[1], va, vb, vc, vd, int'($urandom_range(0, 3)), 1'b0);
    end

    // Reset during MUL cycle 4 with both requesters valid.
    req0_valid = 1'b1; req0_a = {$urandom, $urandom}; req0_b = {$urandom, $urandom};
    req1_valid = 1'b1; req1_a = {$urandom, $urandom}; req1_b = {$urandom, $urandom};
    for (int c = 1; c <= 4; c++) @(negedge clk);
    #1;
    checkOutput("abort_busy_before", RW'(busy), RW'(1));
    #1;
    doReset();
    applyStimulus(1'b1, 1'b1, {$urandom, $urandom}, {$urandom, $urandom},
                  {$urandom, $urandom}, {$urandom, $urandom}, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/elementwise_mult_scheduler.md
Name: elementwise_mult_scheduler

Overview:
- Time-shares one N×N unsigned multiplier between two vector requesters, one element per cycle.
- Each job takes two LEN-element operand vectors and returns their LEN-element elementwise product vector.
- Sits in front of the elementwise multiplication datapath: it arbitrates between requesters, sequences the element loop and buffers the result until it is consumed.

Parameters:
N, 8, operand element width in bits; each product is 2N bits
LEN, 8, elements per vector (>=2)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has a job
req0_ready  output  1  requester 0 job accepted this cycle when high with req0_valid
req0_a  input  LEN*N  requester 0 operand vector A, element i at [i*N +: N]
req0_b  input  LEN*N  requester 0 operand vector B, same packing
req1_valid  input  1  requester 1 has a job
req1_ready  output  1  requester 1 accept
req1_a  input  LEN*N  requester 1 operand vector A
req1_b  input  LEN*N  requester 1 operand vector B
res_valid  output  1  result vector available
res_ready  input  1  consumer takes the result
res_id  output  1  requester that owns the result (0/1)
res_data  output  LEN*2N  product vector, element i at [i*2N +: 2N]
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset
  - Clock and reset: clk rising edge; rst_n asynchronous, active-low.
  - On rst_n low, immediately: state=IDLE, idx=0, res_valid=0, res_id=0, res_data=0, busy=0, operand registers=0, last_grant=1 (requester 0 wins first).
- FSM states: IDLE, MUL, DONE.
- IDLE
  - Grant rule: if exactly one reqX_valid is high, grant X. If both are high, grant the requester other than last_grant.
  - reqX_ready = (state==IDLE) && grant==X. It is combinational from the valids and is low in all other states.
  - On handshake: capture reqX_a/b into internal registers, set res_id=X, last_grant=X, idx=0, state->MUL.
  - If no request, stay in IDLE.
- MUL
  - Each cycle: res_data[idx] <= a_reg[idx]*b_reg[idx], full 2N-bit unsigned product with no truncation; idx increments.
  - When idx==LEN-1: write the last element, then state->DONE and idx->0.
  - Requester inputs are ignored; the captured copies are used, so requesters may change operands after the handshake.
- DONE
  - res_valid=1 and res_data/res_id are held stable.
  - On res_valid&&res_ready: res_valid->0, state->IDLE.
  - No bypass: a new job can be accepted no earlier than the cycle after the result transfer.
- Timing
  - Handshake in cycle 0; MUL occupies cycles 1..LEN; res_valid first high in cycle LEN+1.
  - With res_ready tied high, throughput is one job per LEN+2 cycles.
- res_data between jobs: not cleared. Every element is rewritten before res_valid rises; intermediate contents are visible only while res_valid=0 and are don't-care.
- Boundary conditions
  - Requester handshake rule: a requester must hold valid and operands until its ready. The scheduler does not check this; a request withdrawn before grant is simply not served.
  - Both valids arriving while busy: nothing is accepted; arbitration is evaluated in IDLE only.
  - res_ready high outside DONE: no effect.
  - Reset mid-job: the job is aborted with no res_valid. After release, state is IDLE and requester 0 has priority.
  - Same requester continuously valid and the other idle: it is granted every job.

Test Plan:
- Single job, LEN=8, N=8: req0 only, a[i]=i+1, b[i]=2, res_ready=1. Expect req0_ready high in cycle 0, busy high cycles 1..9, res_valid in cycle 9, res_id=0, res_data[i]=2i+2, next accept no earlier than cycle 10.
- Width: a[i]=255, b[i]=255 for all i. Expect every element =65025 (0xFE01) with no truncation; a[i]=0 gives 0.
- Round robin: after reset, both valids held high for 4 jobs. Expect grants 0,1,0,1 with matching res_id; req0 uses a[i]=i, b[i]=3 → res_data[i]=3i; req1 uses a[i]=i, b[i]=5 → res_data[i]=5i.
- Backpressure: res_ready low for 5 cycles after res_valid rises. Expect res_valid, res_data and res_id stable; both readys low; transfer and return to IDLE on the cycle res_ready rises.
- Operand isolation: after the handshake, req0_a changes to all 0xAA. Expect the result to reflect the captured operands only.
- Reset mid-job: drop rst_n during MUL cycle 4 with both requesters valid. Expect all outputs 0 asynchronously, no res_valid. After release, requester 0 is granted first and its job completes correctly.
